// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM state encoding and PPROT bit positions.
// Used by apb_requester and apb_completer.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_req_state_e;

    localparam int PPROT_PRIV   = 0;
    localparam int PPROT_NONSEC = 1;
    localparam int PPROT_INSTR  = 2;

endpackage : apb_pkg

// File: rtl/apb_requester_if.sv
// Request/response port and APB bus of the requester, bundled as one interface.
// master = requester side, slave = core-side command source plus the APB completer.
interface apb_requester_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [STRB_WIDTH-1:0] req_strb;
    logic [2:0]            req_prot;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_error;
    logic                  rsp_timeout;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [STRB_WIDTH-1:0] PSTRB;
    logic [2:0]            PPROT;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );

endinterface : apb_requester_if

// File: rtl/apb_req_timer.sv
// ACCESS-phase watchdog: counts consecutive stalled cycles and flags the
// TIMEOUT_CYCLES-th one. Only instantiated when APB_REQ_TIMEOUT_EN is defined.
module apb_req_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic stall,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_STALL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Combinational flag so the abort happens on the stalled cycle itself.
    assign expired = stall && (cnt_q == LAST_STALL);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (stall && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : apb_req_timer

// File: rtl/apb_requester.sv
// APB4 requester: one SETUP->ACCESS transfer per accepted command, registered response pulse.
// Optional ACCESS wait-state watchdog enabled by defining APB_REQ_TIMEOUT_EN.
module apb_requester #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    apb_requester_if.master bus
);
    import apb_pkg::*;

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    apb_req_state_e        state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] strb_q, strb_d;
    logic [2:0]            prot_q, prot_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  timeout_hit;

`ifdef APB_REQ_TIMEOUT_EN
    apb_req_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (PCLK),
        .rst_n  (PRESETn),
        .clear  (state_q == SETUP),
        .stall  ((state_q == ACCESS) && !bus.PREADY),
        .expired(timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        write_d       = write_q;
        wdata_d       = wdata_q;
        strb_d        = strb_q;
        prot_d        = prot_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    write_d = bus.req_write;
                    wdata_d = bus.req_wdata;
                    strb_d  = bus.req_write ? bus.req_strb : '0;
                    prot_d  = bus.req_prot;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // PREADY is tested first so a completion on the last allowed cycle beats the watchdog.
                if (bus.PREADY) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = write_q ? '0 : bus.PRDATA;
                    rsp_error_d   = bus.PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            strb_q        <= '0;
            prot_q        <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            write_q       <= write_d;
            wdata_q       <= wdata_d;
            strb_q        <= strb_d;
            prot_q        <= prot_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Select/enable decode straight from state so an async reset drops them immediately.
    assign bus.req_ready   = (state_q == IDLE);
    assign bus.PSEL        = (state_q != IDLE);
    assign bus.PENABLE     = (state_q == ACCESS);
    assign bus.PADDR       = addr_q;
    assign bus.PWRITE      = write_q;
    assign bus.PWDATA      = wdata_q;
    assign bus.PSTRB       = strb_q;
    assign bus.PPROT       = prot_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_error   = rsp_error_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule : apb_requester

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: latency, wait states, PSLVERR, back-to-back
// commands, async reset abort and (with APB_REQ_TIMEOUT_EN) the watchdog.
module tb_apb_requester;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   rsp_cnt;
    int   cyc;

    apb_requester_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_requester #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK   (clk),
        .PRESETn(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [2:0] prot);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_strb  = strb;
        bus.req_prot  = prot;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_strb  = '0;
        bus.req_prot  = '0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b1;
        bus.PSLVERR   = 1'b0;

        // Reset state
        #1;
        check("rst_ready",   bus.req_ready,   1'b1);
        check("rst_psel",    bus.PSEL,        1'b0);
        check("rst_penable", bus.PENABLE,     1'b0);
        check("rst_rspv",    bus.rsp_valid,   1'b0);
        check("rst_err",     bus.rsp_error,   1'b0);
        check("rst_tmo",     bus.rsp_timeout, 1'b0);
        check("rst_paddr",   bus.PADDR,       32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1. Zero-wait write
        issue(1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 3'b010);
        check("t1_ready_idle", bus.req_ready, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        check("t1_psel_n1",    bus.PSEL,      1'b1);
        check("t1_pen_n1",     bus.PENABLE,   1'b0);
        check("t1_ready_n1",   bus.req_ready, 1'b0);
        check("t1_paddr",      bus.PADDR,     32'h8000_0004);
        check("t1_pwrite",     bus.PWRITE,    1'b1);
        check("t1_pwdata",     bus.PWDATA,    32'hDEAD_BEEF);
        check("t1_pstrb",      bus.PSTRB,     4'hF);
        check("t1_pprot",      bus.PPROT,     3'b010);
        tick();
        check("t1_pen_n2",     bus.PENABLE,   1'b1);
        check("t1_rspv_n2",    bus.rsp_valid, 1'b0);
        tick();
        check("t1_rspv_n3",    bus.rsp_valid, 1'b1);
        check("t1_ready_n3",   bus.req_ready, 1'b1);
        check("t1_err",        bus.rsp_error, 1'b0);
        check("t1_rdata",      bus.rsp_rdata, 32'h0);
        check("t1_psel_n3",    bus.PSEL,      1'b0);
        tick();
        check("t1_rspv_pulse", bus.rsp_valid, 1'b0);
        check("t1_paddr_hold", bus.PADDR,     32'h8000_0004);

        // 2. Read with three stalled ACCESS cycles
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'h1234_5678;
        issue(1'b0, 32'h8000_0008, 32'h5555_AAAA, 4'hF, 3'b000);
        tick();
        bus.req_valid = 1'b0;
        check("t2_pstrb_setup", bus.PSTRB,  4'h0);
        check("t2_pwrite",      bus.PWRITE, 1'b0);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check("t2_pen_stall",   bus.PENABLE,   1'b1);
            check("t2_paddr_stall", bus.PADDR,     32'h8000_0008);
            check("t2_pstrb_stall", bus.PSTRB,     4'h0);
            check("t2_rspv_stall",  bus.rsp_valid, 1'b0);
        end
        tick();
        bus.PREADY = 1'b1;
        check("t2_pen_n5",   bus.PENABLE,   1'b1);
        check("t2_rspv_n5",  bus.rsp_valid, 1'b0);
        tick();
        check("t2_rspv_n6",  bus.rsp_valid, 1'b1);
        check("t2_rdata",    bus.rsp_rdata, 32'h1234_5678);
        check("t2_err",      bus.rsp_error, 1'b0);

        // 3. Read completing with PSLVERR
        bus.PRDATA  = 32'hCAFE_F00D;
        bus.PSLVERR = 1'b1;
        issue(1'b0, 32'h8000_0010, 32'h0, 4'hF, 3'b001);
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        bus.PSLVERR = 1'b0;
        check("t3_rspv",  bus.rsp_valid,   1'b1);
        check("t3_err",   bus.rsp_error,   1'b1);
        check("t3_tmo",   bus.rsp_timeout, 1'b0);
        check("t3_rdata", bus.rsp_rdata,   32'hCAFE_F00D);
        tick();
        check("t3_err_hold", bus.rsp_error, 1'b1);

        // 4. Four back-to-back zero-wait writes with req_valid held high
        rsp_cnt = 0;
        cyc     = 0;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 32'h0000_0100 + 32'(4 * i), 32'(i + 1), 4'h3, 3'b000);
            check("t4_ready_idle", bus.req_ready, 1'b1);
            tick();
            cyc++;
            if (bus.rsp_valid) rsp_cnt++;
            check("t4_ready_setup", bus.req_ready, 1'b0);
            check("t4_paddr",       bus.PADDR,     32'h0000_0100 + 32'(4 * i));
            check("t4_pwdata",      bus.PWDATA,    32'(i + 1));
            tick();
            cyc++;
            if (bus.rsp_valid) rsp_cnt++;
            check("t4_ready_access", bus.req_ready, 1'b0);
            tick();
            cyc++;
            if (bus.rsp_valid) rsp_cnt++;
        end
        bus.req_valid = 1'b0;
        check("t4_rsp_count", 64'(rsp_cnt), 64'd4);
        check("t4_cycles",    64'(cyc),     64'd12);
        check("t4_err",       bus.rsp_error, 1'b0);
        tick();

`ifdef APB_REQ_TIMEOUT_EN
        // 5a. PREADY stuck low: abort on the 4th stalled cycle
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'hA5A5_A5A5;
        issue(1'b0, 32'h8000_0040, 32'h0, 4'hF, 3'b000);
        tick();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t5_pen_stall",  bus.PENABLE,   1'b1);
            check("t5_rspv_stall", bus.rsp_valid, 1'b0);
        end
        tick();
        check("t5_rspv",  bus.rsp_valid,   1'b1);
        check("t5_err",   bus.rsp_error,   1'b1);
        check("t5_tmo",   bus.rsp_timeout, 1'b1);
        check("t5_rdata", bus.rsp_rdata,   32'h0);
        check("t5_psel",  bus.PSEL,        1'b0);

        // 5b. PREADY rises on the 4th ACCESS cycle: normal completion
        issue(1'b0, 32'h8000_0044, 32'h0, 4'hF, 3'b000);
        tick();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        tick();
        bus.PREADY = 1'b1;
        check("t5b_pen_4th", bus.PENABLE, 1'b1);
        tick();
        check("t5b_rspv",  bus.rsp_valid,   1'b1);
        check("t5b_tmo",   bus.rsp_timeout, 1'b0);
        check("t5b_err",   bus.rsp_error,   1'b0);
        check("t5b_rdata", bus.rsp_rdata,   32'hA5A5_A5A5);
        tick();
`endif

        // 6. Async reset during ACCESS
        bus.PREADY = 1'b0;
        issue(1'b1, 32'h8000_0020, 32'h0BAD_F00D, 4'hF, 3'b000);
        tick();
        bus.req_valid = 1'b0;
        tick();
        check("t6_pen_access", bus.PENABLE, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_psel_async",  bus.PSEL,      1'b0);
        check("t6_pen_async",   bus.PENABLE,   1'b0);
        check("t6_ready_async", bus.req_ready, 1'b1);
        check("t6_rspv_async",  bus.rsp_valid, 1'b0);
        tick();
        check("t6_rspv_inrst",  bus.rsp_valid, 1'b0);
        tick();
        rst_n      = 1'b1;
        bus.PREADY = 1'b1;
        tick();
        check("t6_rspv_after",  bus.rsp_valid, 1'b0);
        check("t6_ready_after", bus.req_ready, 1'b1);
        check("t6_psel_after",  bus.PSEL,      1'b0);
        check("t6_paddr_after", bus.PADDR,     32'h0);
        tick();
        check("t6_rspv_later",  bus.rsp_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_apb_requester
